// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the MIPS core.
// Decodes the held instruction and sequences the datapath through FETCH,
// DECODE and up to three execute states, with a memory-ready handshake,
// a one-instruction branch delay slot and a HALTED state for illegal code.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   instr                 IR contents (raw memory data while in FETCH)
//   mem_ready             memory access completes this cycle
//   alu_zero, alu_neg     ALU result flags used by conditional branches
//   active                low only in HALTED
//   state_o               current state, for debug
//   ir_write .. bt_write  single-bit datapath controls
//   alu_src_b, pc_src     datapath mux selects
//   alu_op, zero_ext      ALU operation and immediate extension mode
module mips_multicycle_ctrl #(
    parameter int unsigned ALUOP_WIDTH   = 4,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instr,
    input  logic                   mem_ready,
    input  logic                   alu_zero,
    input  logic                   alu_neg,
    output logic                   active,
    output logic [2:0]             state_o,
    output logic                   ir_write,
    output logic                   iord,
    output logic                   alu_src_a,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   pc_write,
    output logic                   bt_write,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             pc_src,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   zero_ext
);

    localparam int unsigned OP_W = 6;
    localparam int unsigned AO_W = 4;

    // Opcodes
    localparam logic [OP_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OPC_J     = 6'h02;
    localparam logic [OP_W-1:0] OPC_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OPC_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OPC_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OPC_BGTZ  = 6'h07;
    localparam logic [OP_W-1:0] OPC_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OPC_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OPC_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OPC_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OPC_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OPC_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OPC_LB    = 6'h20;
    localparam logic [OP_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OP_W-1:0] OPC_SW    = 6'h2B;

    // R-type function codes
    localparam logic [OP_W-1:0] FN_JR   = 6'h08;
    localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
    localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
    localparam logic [OP_W-1:0] FN_AND  = 6'h24;
    localparam logic [OP_W-1:0] FN_OR   = 6'h25;
    localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
    localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;
    localparam logic [OP_W-1:0] FN_SLTU = 6'h2B;

    // ALU operation encodings
    localparam logic [AO_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [AO_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [AO_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [AO_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [AO_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [AO_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [AO_W-1:0] ALU_SLTU = 4'b1000;
    localparam logic [AO_W-1:0] ALU_LUI  = 4'b1001;

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC_1 = 3'b010,
        S_EXEC_2 = 3'b011,
        S_EXEC_3 = 3'b100,
        S_HALTED = 3'b101
    } state_t;

    state_t          state, state_nxt;
    logic            delay_pending, delay_pending_nxt;
    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;
    logic            mem_done;
    logic            op_legal;
    logic            br_taken;
    logic [AO_W-1:0] alu_op4;
    logic            unused_instr;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_instr = ^instr[25:6];
    assign state_o      = state;
    assign alu_op       = ALUOP_WIDTH'(alu_op4);

    // Without the handshake every memory access completes in one cycle.
    assign mem_done = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // Opcodes that DECODE accepts; unknown R-type functs are trapped in EXEC_1.
    always_comb begin
        case (opcode)
            OPC_RTYPE, OPC_J, OPC_JAL, OPC_BEQ, OPC_BNE, OPC_BGTZ,
            OPC_ADDIU, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI,
            OPC_LB, OPC_LW, OPC_SW: op_legal = 1'b1;
            default:                op_legal = 1'b0;
        endcase
    end

    // Branch condition from the EXEC_1 compare; BGTZ is taken when rs > 0.
    always_comb begin
        case (opcode)
            OPC_BEQ:  br_taken = alu_zero;
            OPC_BNE:  br_taken = !alu_zero;
            OPC_BGTZ: br_taken = !alu_zero && !alu_neg;
            default:  br_taken = 1'b0;
        endcase
    end

    // State and delay-slot flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_FETCH;
            delay_pending <= 1'b0;
        end else begin
            state         <= state_nxt;
            delay_pending <= delay_pending_nxt;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt         = state;
        delay_pending_nxt = delay_pending;
        active            = 1'b1;
        ir_write          = 1'b0;
        iord              = 1'b0;
        alu_src_a         = 1'b0;
        reg_dst           = 1'b0;
        mem_to_reg        = 1'b0;
        reg_write         = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        pc_write          = 1'b0;
        bt_write          = 1'b0;
        alu_src_b         = 2'b00;
        pc_src            = 2'b00;
        alu_op4           = ALU_AND;
        zero_ext          = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op4   = ALU_ADD;
                if (mem_done) begin
                    ir_write          = 1'b1;
                    pc_write          = 1'b1;
                    // Delay-slot fetch redirects the PC to the saved target.
                    pc_src            = delay_pending ? 2'b10 : 2'b00;
                    delay_pending_nxt = 1'b0;
                    state_nxt         = S_DECODE;
                end
            end

            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op4   = ALU_ADD;
                state_nxt = op_legal ? S_EXEC_1 : S_HALTED;
            end

            S_EXEC_1: begin
                case (opcode)
                    OPC_RTYPE: begin
                        state_nxt = S_EXEC_2;
                        alu_src_a = 1'b1;
                        case (funct)
                            FN_ADDU: alu_op4 = ALU_ADD;
                            FN_SUBU: alu_op4 = ALU_SUB;
                            FN_AND:  alu_op4 = ALU_AND;
                            FN_OR:   alu_op4 = ALU_OR;
                            FN_XOR:  alu_op4 = ALU_XOR;
                            FN_SLT:  alu_op4 = ALU_SLT;
                            FN_SLTU: alu_op4 = ALU_SLTU;
                            FN_JR: begin
                                alu_src_a         = 1'b0;
                                bt_write          = 1'b1;
                                pc_src            = 2'b11;
                                delay_pending_nxt = 1'b1;
                                state_nxt         = S_FETCH;
                            end
                            default: begin
                                alu_src_a = 1'b0;
                                state_nxt = S_HALTED;
                            end
                        endcase
                    end
                    OPC_ADDIU, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_nxt = S_EXEC_2;
                        case (opcode)
                            OPC_SLTI: alu_op4 = ALU_SLT;
                            OPC_ANDI: alu_op4 = ALU_AND;
                            OPC_ORI:  alu_op4 = ALU_OR;
                            OPC_XORI: alu_op4 = ALU_XOR;
                            OPC_LUI:  alu_op4 = ALU_LUI;
                            default:  alu_op4 = ALU_ADD;
                        endcase
                        zero_ext = (opcode == OPC_ANDI) || (opcode == OPC_ORI) ||
                                   (opcode == OPC_XORI);
                    end
                    OPC_LW, OPC_LB, OPC_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        alu_op4   = ALU_ADD;
                        state_nxt = S_EXEC_2;
                    end
                    OPC_BEQ, OPC_BNE, OPC_BGTZ: begin
                        alu_src_a = 1'b1;
                        alu_op4   = (opcode == OPC_BGTZ) ? ALU_SLT : ALU_SUB;
                        state_nxt = S_FETCH;
                        if (br_taken) begin
                            // Latch the target computed in DECODE.
                            bt_write          = 1'b1;
                            delay_pending_nxt = 1'b1;
                        end
                    end
                    OPC_J, OPC_JAL: begin
                        bt_write          = 1'b1;
                        pc_src            = 2'b01;
                        reg_write         = (opcode == OPC_JAL);
                        delay_pending_nxt = 1'b1;
                        state_nxt         = S_FETCH;
                    end
                    default: state_nxt = S_HALTED;
                endcase
            end

            S_EXEC_2: begin
                case (opcode)
                    OPC_RTYPE: begin
                        reg_dst   = 1'b1;
                        reg_write = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OPC_ADDIU, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI: begin
                        reg_write = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OPC_LW, OPC_LB: begin
                        iord     = 1'b1;
                        mem_read = 1'b1;
                        if (mem_done) state_nxt = S_EXEC_3;
                    end
                    OPC_SW: begin
                        iord      = 1'b1;
                        mem_write = 1'b1;
                        if (mem_done) state_nxt = S_FETCH;
                    end
                    default: state_nxt = S_HALTED;
                endcase
            end

            S_EXEC_3: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end

            S_HALTED: begin
                active    = 1'b0;
                state_nxt = S_HALTED;
            end

            default: state_nxt = S_FETCH;
        endcase

        // No architectural state may change in a reset cycle.
        if (reset) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            bt_write  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl: one instance with
// the memory handshake, one with fixed single-cycle memory.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake instance
    logic        reset, mem_ready, alu_zero, alu_neg;
    logic [31:0] instr;
    logic        active, ir_write, iord, alu_src_a, reg_dst, mem_to_reg, reg_write;
    logic        mem_read, mem_write, pc_write, bt_write, zero_ext;
    logic [2:0]  state_o;
    logic [1:0]  alu_src_b, pc_src;
    logic [3:0]  alu_op;
    logic [19:0] outs;

    // Fixed-latency instance
    logic        h_reset, h_mem_ready, h_alu_zero, h_alu_neg;
    logic [31:0] h_instr;
    logic        h_active, h_ir_write, h_iord, h_alu_src_a, h_reg_dst, h_mem_to_reg;
    logic        h_reg_write, h_mem_read, h_mem_write, h_pc_write, h_bt_write, h_zero_ext;
    logic [2:0]  h_state_o;
    logic [1:0]  h_alu_src_b, h_pc_src;
    logic [3:0]  h_alu_op;
    logic [19:0] h_outs;

    mips_multicycle_ctrl #(.ALUOP_WIDTH(4), .MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .active(active), .state_o(state_o),
        .ir_write(ir_write), .iord(iord), .alu_src_a(alu_src_a), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .pc_write(pc_write), .bt_write(bt_write),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .zero_ext(zero_ext)
    );

    mips_multicycle_ctrl #(.ALUOP_WIDTH(4), .MEM_HANDSHAKE(1'b0)) dut_h0 (
        .clk(clk), .reset(h_reset), .instr(h_instr), .mem_ready(h_mem_ready),
        .alu_zero(h_alu_zero), .alu_neg(h_alu_neg), .active(h_active), .state_o(h_state_o),
        .ir_write(h_ir_write), .iord(h_iord), .alu_src_a(h_alu_src_a), .reg_dst(h_reg_dst),
        .mem_to_reg(h_mem_to_reg), .reg_write(h_reg_write), .mem_read(h_mem_read),
        .mem_write(h_mem_write), .pc_write(h_pc_write), .bt_write(h_bt_write),
        .alu_src_b(h_alu_src_b), .pc_src(h_pc_src), .alu_op(h_alu_op), .zero_ext(h_zero_ext)
    );

    assign outs   = {active, ir_write, iord, alu_src_a, reg_dst, mem_to_reg, reg_write,
                     mem_read, mem_write, pc_write, bt_write, alu_src_b, pc_src, alu_op, zero_ext};
    assign h_outs = {h_active, h_ir_write, h_iord, h_alu_src_a, h_reg_dst, h_mem_to_reg,
                     h_reg_write, h_mem_read, h_mem_write, h_pc_write, h_bt_write,
                     h_alu_src_b, h_pc_src, h_alu_op, h_zero_ext};

    // Output bit positions in the packed vector above
    localparam logic [19:0] ACT    = 20'h80000;
    localparam logic [19:0] IRW    = 20'h40000;
    localparam logic [19:0] IORD   = 20'h20000;
    localparam logic [19:0] SRCA   = 20'h10000;
    localparam logic [19:0] RDST   = 20'h08000;
    localparam logic [19:0] MTR    = 20'h04000;
    localparam logic [19:0] RW     = 20'h02000;
    localparam logic [19:0] MRD    = 20'h01000;
    localparam logic [19:0] MWR    = 20'h00800;
    localparam logic [19:0] PCW    = 20'h00400;
    localparam logic [19:0] BTW    = 20'h00200;
    localparam logic [19:0] SB_4   = 20'h00080;
    localparam logic [19:0] SB_IMM = 20'h00100;
    localparam logic [19:0] SB_SH  = 20'h00180;
    localparam logic [19:0] PC_JT  = 20'h00020;
    localparam logic [19:0] PC_BT  = 20'h00040;
    localparam logic [19:0] PC_RA  = 20'h00060;
    localparam logic [19:0] OP_AND = 20'h00000;
    localparam logic [19:0] OP_OR  = 20'h00002;
    localparam logic [19:0] OP_ADD = 20'h00004;
    localparam logic [19:0] OP_SUB = 20'h0000C;
    localparam logic [19:0] OP_SLT = 20'h0000E;
    localparam logic [19:0] OP_LUI = 20'h00012;
    localparam logic [19:0] ZX     = 20'h00001;

    localparam logic [19:0] F_RDY  = ACT | IRW | MRD | PCW | SB_4 | OP_ADD;
    localparam logic [19:0] F_BT   = F_RDY | PC_BT;
    localparam logic [19:0] F_WAIT = ACT | MRD | SB_4 | OP_ADD;
    localparam logic [19:0] DEC    = ACT | SB_SH | OP_ADD;
    localparam logic [19:0] MEMA   = ACT | SRCA | SB_IMM | OP_ADD;
    localparam logic [19:0] IMMW   = ACT | RW;
    localparam logic [19:0] RWB    = ACT | RDST | RW;

    localparam logic [31:0] I_ADDU  = 32'h00221821;
    localparam logic [31:0] I_SLT   = 32'h0022182A;
    localparam logic [31:0] I_JR    = 32'h03E00008;
    localparam logic [31:0] I_BADF  = 32'h0000003F;
    localparam logic [31:0] I_LW    = 32'h8C220004;
    localparam logic [31:0] I_SW    = 32'hAC220008;
    localparam logic [31:0] I_BEQ   = 32'h10220003;
    localparam logic [31:0] I_BNE   = 32'h14220003;
    localparam logic [31:0] I_BGTZ  = 32'h1C200004;
    localparam logic [31:0] I_J     = 32'h08000010;
    localparam logic [31:0] I_ORI   = 32'h34220005;
    localparam logic [31:0] I_ANDI  = 32'h302200FF;
    localparam logic [31:0] I_ADDIU = 32'h24220001;
    localparam logic [31:0] I_LUI   = 32'h3C011234;
    localparam logic [31:0] I_ILL   = 32'hFC000000;

    typedef struct {
        string       tag;
        logic        rst;
        logic [31:0] ins;
        logic        rdy;
        logic        z;
        logic        n;
        logic [2:0]  st;
        logic [19:0] out;
    } vec_t;

    vec_t main_q[$];
    vec_t h0_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic add(input bit to_h0, input string tag, input logic rst,
                       input logic [31:0] ins, input logic rdy, input logic z,
                       input logic n, input logic [2:0] st, input logic [19:0] out);
        vec_t v;
        v.tag = tag; v.rst = rst; v.ins = ins; v.rdy = rdy;
        v.z = z; v.n = n; v.st = st; v.out = out;
        if (to_h0) h0_q.push_back(v);
        else       main_q.push_back(v);
    endtask

    task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    // Drive one vector per cycle away from the rising edge and check the
    // combinational outputs before the next edge.
    task automatic run(input bit on_h0);
        int n = on_h0 ? h0_q.size() : main_q.size();
        for (int i = 0; i < n; i++) begin
            vec_t v = on_h0 ? h0_q[i] : main_q[i];
            @(negedge clk);
            if (on_h0) begin
                h_reset = v.rst; h_instr = v.ins; h_mem_ready = v.rdy;
                h_alu_zero = v.z; h_alu_neg = v.n;
            end else begin
                reset = v.rst; instr = v.ins; mem_ready = v.rdy;
                alu_zero = v.z; alu_neg = v.n;
            end
            #1;
            chk($sformatf("%s#%0d state", v.tag, i),
                20'(on_h0 ? h_state_o : state_o), 20'(v.st));
            chk($sformatf("%s#%0d outs", v.tag, i), on_h0 ? h_outs : outs, v.out);
        end
    endtask

    // Helper for a plain fetch/decode pair with no delay slot pending.
    task automatic fd(input string tag, input logic [31:0] ins, input logic [19:0] f);
        add(0, tag, 0, ins, 1, 0, 0, 3'd0, f);
        add(0, tag, 0, ins, 1, 0, 0, 3'd1, DEC);
    endtask

    initial begin
        reset = 1; instr = '0; mem_ready = 0; alu_zero = 0; alu_neg = 0;
        h_reset = 1; h_instr = '0; h_mem_ready = 0; h_alu_zero = 0; h_alu_neg = 0;

        // Reset cycle: FETCH with writes suppressed
        add(0, "rst", 1, I_ADDU, 1, 0, 0, 3'd0, F_WAIT);
        // ADDU
        fd("addu", I_ADDU, F_RDY);
        add(0, "addu", 0, I_ADDU, 1, 0, 0, 3'd2, ACT | SRCA | OP_ADD);
        add(0, "addu", 0, I_ADDU, 1, 0, 0, 3'd3, RWB);
        // LW with two wait cycles in FETCH and in EXEC_2
        add(0, "lw", 0, I_LW, 0, 0, 0, 3'd0, F_WAIT);
        add(0, "lw", 0, I_LW, 0, 0, 0, 3'd0, F_WAIT);
        fd("lw", I_LW, F_RDY);
        add(0, "lw", 0, I_LW, 1, 0, 0, 3'd2, MEMA);
        add(0, "lw", 0, I_LW, 0, 0, 0, 3'd3, ACT | IORD | MRD);
        add(0, "lw", 0, I_LW, 0, 0, 0, 3'd3, ACT | IORD | MRD);
        add(0, "lw", 0, I_LW, 1, 0, 0, 3'd3, ACT | IORD | MRD);
        add(0, "lw", 0, I_LW, 1, 0, 0, 3'd4, ACT | MTR | RW);
        // BEQ taken, then ORI in the delay slot
        fd("beq", I_BEQ, F_RDY);
        add(0, "beq", 0, I_BEQ, 1, 1, 0, 3'd2, ACT | SRCA | OP_SUB | BTW);
        fd("ori", I_ORI, F_BT);
        add(0, "ori", 0, I_ORI, 1, 0, 0, 3'd2, ACT | SRCA | SB_IMM | OP_OR | ZX);
        add(0, "ori", 0, I_ORI, 1, 0, 0, 3'd3, IMMW);
        // BNE not taken; flag already cleared
        fd("bne", I_BNE, F_RDY);
        add(0, "bne", 0, I_BNE, 1, 1, 0, 3'd2, ACT | SRCA | OP_SUB);
        // SW with one wait cycle in EXEC_2
        fd("sw", I_SW, F_RDY);
        add(0, "sw", 0, I_SW, 1, 0, 0, 3'd2, MEMA);
        add(0, "sw", 0, I_SW, 0, 0, 0, 3'd3, ACT | IORD | MWR);
        add(0, "sw", 0, I_SW, 1, 0, 0, 3'd3, ACT | IORD | MWR);
        // SLT and ANDI
        fd("slt", I_SLT, F_RDY);
        add(0, "slt", 0, I_SLT, 1, 0, 0, 3'd2, ACT | SRCA | OP_SLT);
        add(0, "slt", 0, I_SLT, 1, 0, 0, 3'd3, RWB);
        fd("andi", I_ANDI, F_RDY);
        add(0, "andi", 0, I_ANDI, 1, 0, 0, 3'd2, ACT | SRCA | SB_IMM | OP_AND | ZX);
        add(0, "andi", 0, I_ANDI, 1, 0, 0, 3'd3, IMMW);
        // BGTZ taken, J in its delay slot, ADDIU in the J delay slot
        fd("bgtz", I_BGTZ, F_RDY);
        add(0, "bgtz", 0, I_BGTZ, 1, 0, 0, 3'd2, ACT | SRCA | OP_SLT | BTW);
        fd("j", I_J, F_BT);
        add(0, "j", 0, I_J, 1, 0, 0, 3'd2, ACT | BTW | PC_JT);
        fd("addiu", I_ADDIU, F_BT);
        add(0, "addiu", 0, I_ADDIU, 1, 0, 0, 3'd2, MEMA);
        add(0, "addiu", 0, I_ADDIU, 1, 0, 0, 3'd3, IMMW);
        // BGTZ with negative result: not taken
        fd("bgtzn", I_BGTZ, F_RDY);
        add(0, "bgtzn", 0, I_BGTZ, 1, 0, 1, 3'd2, ACT | SRCA | OP_SLT);
        // JR then LUI in its delay slot
        fd("jr", I_JR, F_RDY);
        add(0, "jr", 0, I_JR, 1, 0, 0, 3'd2, ACT | BTW | PC_RA);
        fd("lui", I_LUI, F_BT);
        add(0, "lui", 0, I_LUI, 1, 0, 0, 3'd2, ACT | SRCA | SB_IMM | OP_LUI);
        add(0, "lui", 0, I_LUI, 1, 0, 0, 3'd3, IMMW);
        // Illegal opcode: HALTED held for 10 cycles, then reset
        fd("ill", I_ILL, F_RDY);
        for (int k = 0; k < 10; k++) add(0, "halt", 0, I_ILL, 1, 0, 0, 3'd5, 20'h0);
        add(0, "halt_rst", 1, I_ILL, 1, 0, 0, 3'd5, 20'h0);
        // Unknown R-type funct halts from EXEC_1
        fd("badf", I_BADF, F_RDY);
        add(0, "badf", 0, I_BADF, 1, 0, 0, 3'd2, ACT);
        add(0, "badf", 1, I_BADF, 1, 0, 0, 3'd5, 20'h0);
        // Reset during SW EXEC_2 suppresses mem_write
        fd("swrst", I_SW, F_RDY);
        add(0, "swrst", 0, I_SW, 1, 0, 0, 3'd2, MEMA);
        add(0, "swrst", 1, I_SW, 1, 0, 0, 3'd3, ACT | IORD);
        // Reset clears a pending delay slot
        fd("beq2", I_BEQ, F_RDY);
        add(0, "beq2", 0, I_BEQ, 1, 1, 0, 3'd2, ACT | SRCA | OP_SUB | BTW);
        add(0, "dprst", 1, I_ADDU, 1, 0, 0, 3'd0, F_WAIT | PC_BT);
        add(0, "dprst", 0, I_ADDU, 1, 0, 0, 3'd0, F_RDY);

        // Fixed-latency instance: mem_ready held low throughout
        add(1, "h0rst", 1, I_ADDU, 0, 0, 0, 3'd0, F_WAIT);
        add(1, "h0addu", 0, I_ADDU, 0, 0, 0, 3'd0, F_RDY);
        add(1, "h0addu", 0, I_ADDU, 0, 0, 0, 3'd1, DEC);
        add(1, "h0addu", 0, I_ADDU, 0, 0, 0, 3'd2, ACT | SRCA | OP_ADD);
        add(1, "h0addu", 0, I_ADDU, 0, 0, 0, 3'd3, RWB);
        add(1, "h0sw", 0, I_SW, 0, 0, 0, 3'd0, F_RDY);
        add(1, "h0sw", 0, I_SW, 0, 0, 0, 3'd1, DEC);
        add(1, "h0sw", 0, I_SW, 0, 0, 0, 3'd2, MEMA);
        add(1, "h0sw", 0, I_SW, 0, 0, 0, 3'd3, ACT | IORD | MWR);
        add(1, "h0lw", 0, I_LW, 0, 0, 0, 3'd0, F_RDY);
        add(1, "h0lw", 0, I_LW, 0, 0, 0, 3'd1, DEC);
        add(1, "h0lw", 0, I_LW, 0, 0, 0, 3'd2, MEMA);
        add(1, "h0lw", 0, I_LW, 0, 0, 0, 3'd3, ACT | IORD | MRD);
        add(1, "h0lw", 0, I_LW, 0, 0, 0, 3'd4, ACT | MTR | RW);
        add(1, "h0end", 0, I_LW, 0, 0, 0, 3'd0, F_RDY);

        repeat (2) @(negedge clk);
        run(1'b0);
        run(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
